// File: rtl/ysyx_24090003_sbus_mem_arbiter.sv
// SimpleBus memory front-end: round-robin arbitration of NCH requesters onto one
// memory port, one outstanding transaction, response after LATENCY cycles.
module ysyx_24090003_sbus_mem_arbiter #(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NCH-1:0]        i_req_valid,
  output logic [NCH-1:0]        o_req_ready,
  input  logic [NCH*AW-1:0]     i_req_addr,
  input  logic [NCH-1:0]        i_req_we,
  input  logic [NCH*DW-1:0]     i_req_wdata,
  input  logic [NCH*DW/8-1:0]   i_req_wmask,
  output logic [NCH-1:0]        o_rsp_valid,
  input  logic [NCH-1:0]        i_rsp_ready,
  output logic [DW-1:0]         o_rsp_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [AW-1:0]         o_mem_addr,
  output logic [DW-1:0]         o_mem_wdata,
  output logic [DW/8-1:0]       o_mem_wmask,
  input  logic [DW-1:0]         i_mem_rdata
);

  localparam int MW = DW / 8;
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // Handshake: a request transfers on a cycle where i_req_valid[k] & o_req_ready[k];
  // a response transfers where o_rsp_valid[k] & i_rsp_ready[k]. Ready never waits on valid's partner.
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, owner, grant;
  logic            grant_any, accept;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   rdata_q;

  // First valid channel at or above the pointer, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(ptr) + i) % NCH;
      if (!grant_any && i_req_valid[idx]) begin
        grant     = PW'(idx);
        grant_any = 1'b1;
      end
    end
  end

  assign accept = (state == IDLE) && grant_any && !i_rst;

  always_comb begin
    o_req_ready = '0;
    o_mem_en    = accept;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wmask = '0;
    if (accept) begin
      o_req_ready = NCH'(1) << grant;
      o_mem_we    = i_req_we[grant];
      o_mem_addr  = i_req_addr[int'(grant)*AW +: AW];
      o_mem_wdata = i_req_wdata[int'(grant)*DW +: DW];
      o_mem_wmask = i_req_wmask[int'(grant)*MW +: MW];
    end
  end

  assign o_rsp_valid = (state == RESP) ? (NCH'(1) << owner) : '0;
  assign o_rsp_rdata = (state == RESP) ? rdata_q : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt <= CW'(1)) state_nxt = RESP;
      RESP: if (i_rsp_ready[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rdata_q <= i_req_we[grant] ? '0 : i_mem_rdata;
        owner   <= grant;
        ptr     <= PW'((int'(grant) + 1) % NCH);
        cnt     <= CW'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24090003_sbus_mem_arbiter.sv
// Bench for the SimpleBus arbiter: three instances with LATENCY 1, 2 and 3,
// directed requests, and a response scoreboard fed from the stimulus side.
module tb_ysyx_24090003_sbus_mem_arbiter;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req_valid [NI], req_ready [NI], req_we [NI], rsp_valid [NI], rsp_ready [NI];
  logic [63:0] req_addr [NI], req_wdata [NI];
  logic [7:0]  req_wmask [NI];
  logic [31:0] rsp_rdata [NI], mem_addr [NI], mem_wdata [NI], mem_rdata [NI];
  logic        mem_en [NI], mem_we [NI];
  logic [3:0]  mem_wmask [NI];

  // Scoreboard entry: {instance[1:0], one-hot channel[1:0], data[31:0]}
  logic [35:0] exp_q[$];
  logic [35:0] e;
  int errors = 0;
  int checks = 0;

  generate
    for (genvar k = 0; k < NI; k++) begin : g_dut
      assign mem_rdata[k] = mem_addr[k] ^ 32'h8000_0297;
      ysyx_24090003_sbus_mem_arbiter #(.NCH(2), .AW(32), .DW(32), .LATENCY(k + 1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid[k]), .o_req_ready(req_ready[k]),
        .i_req_addr(req_addr[k]), .i_req_we(req_we[k]),
        .i_req_wdata(req_wdata[k]), .i_req_wmask(req_wmask[k]),
        .o_rsp_valid(rsp_valid[k]), .i_rsp_ready(rsp_ready[k]), .o_rsp_rdata(rsp_rdata[k]),
        .o_mem_en(mem_en[k]), .o_mem_we(mem_we[k]), .o_mem_addr(mem_addr[k]),
        .o_mem_wdata(mem_wdata[k]), .o_mem_wmask(mem_wmask[k]), .i_mem_rdata(mem_rdata[k])
      );
    end
  endgenerate

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake, plus idle invariants.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NI; k++) begin
        if ((rsp_valid[k] & rsp_ready[k]) != 2'b00) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: inst %0d valid %b data %h", k, rsp_valid[k], rsp_rdata[k]);
          end else begin
            e = exp_q.pop_front();
            check("rsp_inst", 64'(k), 64'(e[35:34]));
            check("rsp_channel", 64'(rsp_valid[k]), 64'(e[33:32]));
            check("rsp_rdata", 64'(rsp_rdata[k]), 64'(e[31:0]));
          end
        end
        if (rsp_valid[k] == 2'b00) check("rdata_zero_when_idle", 64'(rsp_rdata[k]), 64'd0);
        if (!mem_en[k]) begin
          check("mem_quiet_ctl", 64'({mem_we[k], mem_wmask[k], mem_addr[k]}), 64'd0);
          check("mem_quiet_wdata", 64'(mem_wdata[k]), 64'd0);
        end
      end
    end
  end

  task automatic idle_inputs();
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 2'b00; req_we[k] = 2'b00; req_addr[k] = '0;
      req_wdata[k] = '0;    req_wmask[k] = '0; rsp_ready[k] = 2'b11;
    end
  endtask

  task automatic wait_ready(input int k, input logic [1:0] exp_rdy, input string nm, output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready[k] == 2'b00 && n < 20);
    check(nm, 64'(req_ready[k]), 64'(exp_rdy));
    ok = (req_ready[k] != 2'b00);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain_responses", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_req(input int k, input int ch, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask, input logic [31:0] exp_data);
    logic [1:0] exp_rdy;
    bit ok;
    int lat;
    exp_rdy = 2'b01 << ch;
    @(posedge clk); #1;
    req_we[k][ch] = we;
    req_addr[k][ch*32 +: 32] = addr;
    req_wdata[k][ch*32 +: 32] = wdata;
    req_wmask[k][ch*4 +: 4] = wmask;
    req_valid[k][ch] = 1'b1;
    wait_ready(k, exp_rdy, "req_grant", ok);
    check("mem_en", 64'(mem_en[k]), 64'd1);
    check("mem_we", 64'(mem_we[k]), 64'(we));
    check("mem_addr", 64'(mem_addr[k]), 64'(addr));
    check("mem_wdata", 64'(mem_wdata[k]), 64'(wdata));
    check("mem_wmask", 64'(mem_wmask[k]), 64'(wmask));
    if (ok) exp_q.push_back({2'(k), exp_rdy, exp_data});
    @(posedge clk); #1;
    req_valid[k][ch] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("mem_en_one_cycle", 64'(mem_en[k]), 64'd0);
    end while (rsp_valid[k] == 2'b00 && lat < 20);
    check("rsp_latency", 64'(lat), 64'(k + 1));
    drain();
  endtask

  // Both channels hold reads continuously; grants must alternate.
  task automatic rr(input int k, input int n, input int first);
    int exp_ch;
    bit ok;
    @(posedge clk); #1;
    req_we[k] = 2'b00;
    req_addr[k] = {32'h8000_0020, 32'h8000_0010};
    req_valid[k] = 2'b11;
    exp_ch = first;
    for (int i = 0; i < n; i++) begin
      wait_ready(k, 2'b01 << exp_ch, "rr_grant", ok);
      if (!ok) break;
      exp_q.push_back({2'(k), 2'b01 << exp_ch, (exp_ch == 1) ? 32'h0000_02B7 : 32'h0000_0287});
      @(posedge clk);
      exp_ch ^= 1;
    end
    #1 req_valid[k] = 2'b00;
    drain();
  endtask

  // Owner's rsp_ready held low with the other channel's high; a second request waits.
  task automatic backpressure(input int k);
    bit ok;
    int n;
    @(posedge clk); #1;
    rsp_ready[k] = 2'b10;
    req_we[k] = 2'b00;
    req_addr[k][31:0] = 32'h8000_0100;
    req_valid[k][0] = 1'b1;
    wait_ready(k, 2'b01, "bp_grant", ok);
    if (ok) exp_q.push_back({2'(k), 2'b01, 32'h0000_0397});
    @(posedge clk); #1;
    req_valid[k][0] = 1'b0;
    req_addr[k][63:32] = 32'h8000_0200;
    req_valid[k][1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid[k] == 2'b00 && n < 20);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 64'(rsp_valid[k]), 64'(2'b01));
      check("bp_rsp_rdata", 64'(rsp_rdata[k]), 64'h0000_0397);
      check("bp_req_ready", 64'(req_ready[k]), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready[k] = 2'b11;
    wait_ready(k, 2'b10, "bp_next_grant", ok);
    if (ok) exp_q.push_back({2'(k), 2'b10, 32'h0000_0097});
    @(posedge clk); #1;
    req_valid[k][1] = 1'b0;
    drain();
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("reset_req_ready", 64'(req_ready[k]), 64'd0);
      check("reset_rsp_valid", 64'(rsp_valid[k]), 64'd0);
      check("reset_rsp_rdata", 64'(rsp_rdata[k]), 64'd0);
      check("reset_mem_en", 64'(mem_en[k]), 64'd0);
    end
    @(posedge clk); #1 rst = 1'b0;

    // Reset during WAIT on the LATENCY=3 instance aborts the read.
    @(posedge clk); #1;
    req_addr[2][31:0] = 32'h8000_0000;
    req_valid[2][0] = 1'b1;
    wait_ready(2, 2'b01, "abort_grant", ok);
    @(posedge clk); #1 req_valid[2][0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid[2][1] = 1'b1;
    @(negedge clk);
    check("abort_rsp_valid", 64'(rsp_valid[2]), 64'd0);
    check("reset_gates_ready", 64'(req_ready[2]), 64'd0);
    check("reset_gates_mem_en", 64'(mem_en[2]), 64'd0);
    @(posedge clk); #1;
    req_valid[2] = 2'b00;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 64'(rsp_valid[2]), 64'd0);
    end
    rr(2, 2, 0);

    // Single reads at LATENCY=1, channel 0 then channel 1.
    do_req(0, 0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 32'h0000_0297);
    do_req(0, 1, 1'b0, 32'h8000_0004, 32'h0, 4'hF, 32'h0000_0293);

    // Write at LATENCY=2 returns zero data.
    do_req(1, 1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011, 32'h0);

    rr(0, 4, 0);
    backpressure(1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
